// File: rtl/micro_uaz_core.sv
`default_nettype none
// ============================================================================
//  Module   : micro_uaz_core
//  Purpose  : Parametrised multicycle UAZ core. It has eight general registers,
//             {N,C,Z} flags, conditional jumps, a hardware call/return stack
//             and a data bus that uses a req/ack handshake with wait states.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DATA_W       register / ALU / data-bus width (>= 8)
//    PC_W         program counter and instruction address width
//    STACK_DEPTH  number of return-address entries (>= 1)
//  Ports
//    Clk                              in   system clock, rising edge
//    Rst                              in   asynchronous reset, active low
//    i_Instrucciones                  in   instruction at current PC
//    o_Bus_Direcciones_Instrucciones  out  PC register
//    i_Bus_Datos_E                    in   read data, sampled when i_Ack=1
//    o_Bus_Datos_S                    out  write data (registered)
//    o_Bus_Direccion_Datos            out  data address (registered)
//    o_Lectura_Escritura              out  1=write, 0=read, valid with o_Req
//    o_Req                            out  bus request (registered)
//    i_Ack                            in   bus acknowledge
//    o_Banderas                       out  {N,C,Z}
//    o_Stack_Err                      out  sticky stack overflow/underflow
//    o_Halted                         out  core stopped by HALT
// ============================================================================
module micro_uaz_core #(
  parameter int DATA_W      = 8,
  parameter int PC_W        = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [15:0]       i_Instrucciones,
  output logic [PC_W-1:0]   o_Bus_Direcciones_Instrucciones,
  input  logic [DATA_W-1:0] i_Bus_Datos_E,
  output logic [DATA_W-1:0] o_Bus_Datos_S,
  output logic [DATA_W-1:0] o_Bus_Direccion_Datos,
  output logic              o_Lectura_Escritura,
  output logic              o_Req,
  input  logic              i_Ack,
  output logic [2:0]        o_Banderas,
  output logic              o_Stack_Err,
  output logic              o_Halted
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] C_SP_FULL = SP_W'(STACK_DEPTH);

  localparam logic [3:0] C_OP_NOP  = 4'h0;
  localparam logic [3:0] C_OP_LDI  = 4'h1;
  localparam logic [3:0] C_OP_MOV  = 4'h2;
  localparam logic [3:0] C_OP_ADD  = 4'h3;
  localparam logic [3:0] C_OP_SUB  = 4'h4;
  localparam logic [3:0] C_OP_AND  = 4'h5;
  localparam logic [3:0] C_OP_OR   = 4'h6;
  localparam logic [3:0] C_OP_XOR  = 4'h7;
  localparam logic [3:0] C_OP_SHL  = 4'h8;
  localparam logic [3:0] C_OP_LD   = 4'h9;
  localparam logic [3:0] C_OP_ST   = 4'hA;
  localparam logic [3:0] C_OP_JMP  = 4'hB;
  localparam logic [3:0] C_OP_CALL = 4'hC;
  localparam logic [3:0] C_OP_RET  = 4'hD;
  localparam logic [3:0] C_OP_CMP  = 4'hE;
  localparam logic [3:0] C_OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    S_EXEC = 2'd0,
    S_MEM  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t                              state_q, state_d;
  logic [PC_W-1:0]                     pc_q, pc_d;
  logic [7:0][DATA_W-1:0]              regs_q, regs_d;
  logic [2:0]                          flags_q, flags_d;
  logic [SP_W-1:0]                     sp_q, sp_d;
  logic [STACK_DEPTH-1:0][PC_W-1:0]    stack_q, stack_d;
  logic [2:0]                          ld_rx_q, ld_rx_d;
  logic                                req_q, req_d;
  logic                                we_q, we_d;
  logic [DATA_W-1:0]                   dout_q, dout_d;
  logic [DATA_W-1:0]                   addr_q, addr_d;
  logic                                err_q, err_d;
  logic                                halt_q, halt_d;

  // Instruction fields; imm overlaps the low bits of ry by design.
  logic [3:0]        w_op;
  logic [2:0]        w_rx;
  logic [2:0]        w_ry;
  logic [7:0]        w_imm;
  logic [DATA_W-1:0] w_rx_val;
  logic [DATA_W-1:0] w_ry_val;
  logic [DATA_W-1:0] w_imm_ext;
  logic [PC_W-1:0]   w_pc_inc;
  logic [PC_W-1:0]   w_target;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic [DATA_W-1:0] w_shl;
  logic              w_cond;
  logic [IDX_W-1:0]  w_push_idx;
  logic [IDX_W-1:0]  w_pop_idx;

  assign w_op      = i_Instrucciones[15:12];
  assign w_rx      = i_Instrucciones[11:9];
  assign w_ry      = i_Instrucciones[8:6];
  assign w_imm     = i_Instrucciones[7:0];
  assign w_rx_val  = regs_q[w_rx];
  assign w_ry_val  = regs_q[w_ry];
  assign w_imm_ext = DATA_W'(w_imm);
  assign w_pc_inc  = pc_q + PC_W'(1);
  assign w_target  = PC_W'(w_rx_val);

  // One extra bit holds carry-out (add) or borrow (subtract).
  assign w_sum  = {1'b0, w_rx_val} + {1'b0, w_ry_val};
  assign w_diff = {1'b0, w_rx_val} - {1'b0, w_ry_val};
  assign w_shl  = {w_rx_val[DATA_W-2:0], 1'b0};

  assign w_push_idx = IDX_W'(sp_q);
  assign w_pop_idx  = IDX_W'(sp_q - SP_W'(1));

  // Jump condition; flags are {N,C,Z}.
  always_comb begin
    w_cond = 1'b0;
    unique case (w_imm[2:0])
      3'd0: w_cond = 1'b1;
      3'd1: w_cond = flags_q[0];
      3'd2: w_cond = !flags_q[0];
      3'd3: w_cond = flags_q[1];
      3'd4: w_cond = !flags_q[1];
      3'd5: w_cond = flags_q[2];
      3'd6: w_cond = !flags_q[2];
      default: w_cond = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    regs_d  = regs_q;
    flags_d = flags_q;
    sp_d    = sp_q;
    stack_d = stack_q;
    ld_rx_d = ld_rx_q;
    req_d   = req_q;
    we_d    = we_q;
    dout_d  = dout_q;
    addr_d  = addr_q;
    err_d   = err_q;
    halt_d  = halt_q;

    unique case (state_q)
      S_EXEC: begin
        pc_d = w_pc_inc;
        unique case (w_op)
          C_OP_NOP: ;
          C_OP_LDI: regs_d[w_rx] = w_imm_ext;
          C_OP_MOV: regs_d[w_rx] = w_ry_val;
          C_OP_ADD: begin
            regs_d[w_rx] = w_sum[DATA_W-1:0];
            flags_d = {w_sum[DATA_W-1], w_sum[DATA_W], (w_sum[DATA_W-1:0] == '0)};
          end
          C_OP_SUB, C_OP_CMP: begin
            if (w_op == C_OP_SUB) regs_d[w_rx] = w_diff[DATA_W-1:0];
            flags_d = {w_diff[DATA_W-1], w_diff[DATA_W], (w_diff[DATA_W-1:0] == '0)};
          end
          C_OP_AND: begin
            regs_d[w_rx] = w_rx_val & w_ry_val;
            flags_d = {regs_d[w_rx][DATA_W-1], 1'b0, ((w_rx_val & w_ry_val) == '0)};
          end
          C_OP_OR: begin
            regs_d[w_rx] = w_rx_val | w_ry_val;
            flags_d = {regs_d[w_rx][DATA_W-1], 1'b0, ((w_rx_val | w_ry_val) == '0)};
          end
          C_OP_XOR: begin
            regs_d[w_rx] = w_rx_val ^ w_ry_val;
            flags_d = {regs_d[w_rx][DATA_W-1], 1'b0, ((w_rx_val ^ w_ry_val) == '0)};
          end
          C_OP_SHL: begin
            regs_d[w_rx] = w_shl;
            flags_d = {w_shl[DATA_W-1], w_rx_val[DATA_W-1], (w_shl == '0)};
          end
          C_OP_LD, C_OP_ST: begin
            // PC holds until the acknowledge edge.
            pc_d    = pc_q;
            ld_rx_d = w_rx;
            req_d   = 1'b1;
            we_d    = (w_op == C_OP_ST);
            addr_d  = w_ry_val;
            dout_d  = w_rx_val;
            state_d = S_MEM;
          end
          C_OP_JMP: begin
            if (w_cond) pc_d = w_target;
          end
          C_OP_CALL: begin
            if (sp_q == C_SP_FULL) begin
              err_d = 1'b1;
            end else begin
              stack_d[w_push_idx] = w_pc_inc;
              sp_d = sp_q + SP_W'(1);
              pc_d = w_target;
            end
          end
          C_OP_RET: begin
            if (sp_q == '0) begin
              err_d = 1'b1;
            end else begin
              sp_d = sp_q - SP_W'(1);
              pc_d = stack_q[w_pop_idx];
            end
          end
          C_OP_HALT: begin
            // PC stays on the HALT instruction.
            pc_d    = pc_q;
            halt_d  = 1'b1;
            state_d = S_HALT;
          end
          default: ;
        endcase
      end

      S_MEM: begin
        if (i_Ack) begin
          // LD with rx==ry intentionally overwrites the address register.
          if (!we_q) regs_d[ld_rx_q] = i_Bus_Datos_E;
          req_d   = 1'b0;
          we_d    = 1'b0;
          pc_d    = w_pc_inc;
          state_d = S_EXEC;
        end
      end

      S_HALT: ;

      default: state_d = S_EXEC;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_EXEC;
      pc_q    <= '0;
      regs_q  <= '0;
      flags_q <= '0;
      sp_q    <= '0;
      stack_q <= '0;
      ld_rx_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      dout_q  <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      regs_q  <= regs_d;
      flags_q <= flags_d;
      sp_q    <= sp_d;
      stack_q <= stack_d;
      ld_rx_q <= ld_rx_d;
      req_q   <= req_d;
      we_q    <= we_d;
      dout_q  <= dout_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      halt_q  <= halt_d;
    end
  end

  assign o_Bus_Direcciones_Instrucciones = pc_q;
  assign o_Bus_Datos_S                   = dout_q;
  assign o_Bus_Direccion_Datos           = addr_q;
  assign o_Lectura_Escritura             = we_q;
  assign o_Req                           = req_q;
  assign o_Banderas                      = flags_q;
  assign o_Stack_Err                     = err_q;
  assign o_Halted                        = halt_q;

endmodule
`default_nettype wire

// File: doc/micro_uaz_core.md
# micro_uaz_core

Parametrised successor of the 8-bit UAZ microcontroller top level: a multicycle core with configurable data and program-counter widths, eight general registers, Z/C/N flags, conditional jumps, a hardware call/return stack and a data bus with a request/acknowledge handshake that supports wait states. It sits between the instruction ROM (asynchronous read, addressed by the PC) and the data memory or peripheral fabric.

## Interface
- DATA_W, 8, register/ALU/data-bus width; must be at least 8.
- PC_W, 8, program counter and instruction address width.
- STACK_DEPTH, 4, number of return-address entries; must be at least 1.

- Clk  in  1  system clock, rising edge.
- Rst  in  1  reset; asynchronous, active-low.
- i_Instrucciones  in  16  instruction at current PC; valid in the same cycle.
- o_Bus_Direcciones_Instrucciones  out  PC_W  PC register.
- i_Bus_Datos_E  in  DATA_W  read data; sampled when i_Ack=1.
- o_Bus_Datos_S  out  DATA_W  write data; registered.
- o_Bus_Direccion_Datos  out  DATA_W  data address; registered.
- o_Lectura_Escritura  out  1  1=write, 0=read; valid while o_Req=1.
- o_Req  out  1  bus request; registered.
- i_Ack  in  1  bus acknowledge.
- o_Banderas  out  3  {N,C,Z} flag register.
- o_Stack_Err  out  1  sticky stack overflow/underflow flag.
- o_Halted  out  1  core stopped by HALT.

## Operation
- Instruction fields: op[15:12], rx[11:9], ry[8:6], imm[7:0]. imm is zero-extended to DATA_W.
- Opcodes:
  - 0 NOP.
  - 1 LDI: rx←imm.
  - 2 MOV: rx←ry.
  - 3 ADD: rx←rx+ry.
  - 4 SUB: rx←rx−ry.
  - 5 AND, 6 OR, 7 XOR: rx←rx op ry.
  - 8 SHL: rx←rx<<1.
  - 9 LD: rx←mem[ry].
  - A ST: mem[ry]←rx.
  - B JMP: if cond, PC←rx.
  - C CALL: push PC+1, then PC←rx.
  - D RET: PC←pop.
  - E CMP: flags from rx−ry; no register write.
  - F HALT.
- Jump condition is imm[2:0]: 0 always, 1 Z, 2 !Z, 3 C, 4 !C, 5 N, 6 !N, 7 never.
- Jump and call targets use rx truncated or zero-extended to PC_W.
- Flags are updated only by ADD, SUB, AND, OR, XOR, SHL and CMP:
  - Z: result is 0.
  - N: result MSB.
  - C: carry-out for ADD; borrow for SUB/CMP (1 when rx<ry unsigned); shifted-out MSB for SHL; 0 for logic ops.
- Arithmetic is modulo 2^DATA_W. The PC wraps from 2^PC_W−1 to 0.
- When an instruction does not jump, PC←PC+1.
- State machine:
  - EXEC: decode i_Instrucciones and complete all non-memory ops in one cycle. LD/ST latch the instruction register, drive address, data and direction, set o_Req, and go to MEM. HALT sets o_Halted and goes to HALT.
  - MEM: hold all bus outputs. On a rising edge with i_Ack=1: LD writes i_Bus_Datos_E to rx, o_Req clears, PC advances, go to EXEC. With i_Ack=0, wait indefinitely.
  - HALT: stays in HALT until reset; PC is frozen.
- Stack boundaries:
  - CALL with stack full: no push, PC←PC+1, o_Stack_Err←1.
  - RET with stack empty: PC←PC+1, o_Stack_Err←1.
  - o_Stack_Err clears only on reset.
- i_Ack while o_Req=0 is ignored.
- LD with rx==ry: the loaded value overwrites the address register.

## Timing
- Reset values: PC, all registers, flags, stack pointer, o_Req, o_Lectura_Escritura, o_Bus_Datos_S, o_Bus_Direccion_Datos, o_Stack_Err and o_Halted are all 0; state is EXEC.
- Reset asserted mid-MEM drops o_Req immediately (asynchronous); the access is abandoned.
- Non-memory instruction: 1 cycle. The register/flag write and the PC update occur at the same edge.
- LD/ST: o_Req rises at the edge ending the EXEC cycle. Total cycles = 1 + (cycles until i_Ack sampled high); minimum 2.
- The next instruction is decoded in the cycle after the acknowledge edge.
- CALL/RET: 1 cycle. The push or pop and the PC load occur at the same edge.

## Test plan
- Reset, then LDI r1,5; LDI r2,3; ADD r1,r2 → r1=8, flags Z=0 C=0 N=0, PC=3 after 3 cycles.
- With DATA_W=8: LDI r1,0xFF; LDI r2,1; ADD r1,r2 → r1=0, Z=1, C=1. Then SUB r1,r2 → r1=0xFF, C=1, N=1.
- ST r3→[r4] with i_Ack delayed 3 cycles → o_Req high for exactly 4 cycles, o_Lectura_Escritura=1, PC does not advance until the acknowledge edge. LD with i_Bus_Datos_E=0xA5 and i_Ack in the first MEM cycle → rx=0xA5 in 2 cycles total.
- CMP equal operands, then JMP cond=1 to r5=0x40 → PC=0x40. JMP cond=2 on the same flags → PC=PC+1.
- With STACK_DEPTH=4: five nested CALLs → fifth one is not taken, o_Stack_Err=1. Four RETs return in LIFO order; a fifth RET leaves PC+1.
- Rst low during MEM → o_Req=0 within the same cycle, all outputs at reset values. HALT → o_Halted=1 and PC frozen for 10 cycles.
